vga_timing_gen: RTL

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_pkg.sv | 29 ++
 rtl/vga_timing_gen_if.sv | 44 ++++
 rtl/vga_axis_counter.sv | 69 ++++++
 rtl/vga_timing_gen.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared widths, default 640x480 timing and the per-axis region encoding
// used by vga_timing_gen and its axis counters.
package vga_pkg;

  localparam int unsigned VGA_REZ_MAX_WIDTH   = 11;
  localparam int unsigned VGA_PULSE_WIDTH     = 8;
  localparam int unsigned VGA_HL_MARGIN_WIDTH = 8;
  localparam int unsigned VGA_HR_MARGIN_WIDTH = 8;
  localparam int unsigned VGA_VL_MARGIN_WIDTH = 8;
  localparam int unsigned VGA_VR_MARGIN_WIDTH = 8;

  // 640x480@60: count_max / sync / back porch / front porch
  localparam int unsigned DEF_H_COUNT_MAX    = 799;
  localparam int unsigned DEF_H_SYNC_PULSE   = 96;
  localparam int unsigned DEF_H_LEFT_MARGIN  = 48;
  localparam int unsigned DEF_H_RIGHT_MARGIN = 16;
  localparam int unsigned DEF_V_COUNT_MAX    = 524;
  localparam int unsigned DEF_V_SYNC_PULSE   = 2;
  localparam int unsigned DEF_V_LEFT_MARGIN  = 33;
  localparam int unsigned DEF_V_RIGHT_MARGIN = 10;

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    BACK   = 2'd1,
    ACTIVE = 2'd2,
    FRONT  = 2'd3
  } region_e;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Configuration inputs and video timing outputs of vga_timing_gen.
// master = configuring/consuming side, slave = the timing generator.
interface vga_timing_gen_if
  import vga_pkg::*;
#(
  parameter int unsigned REZ_MAX_WIDTH   = VGA_REZ_MAX_WIDTH,
  parameter int unsigned PULSE_WIDTH     = VGA_PULSE_WIDTH,
  parameter int unsigned HL_MARGIN_WIDTH = VGA_HL_MARGIN_WIDTH,
  parameter int unsigned HR_MARGIN_WIDTH = VGA_HR_MARGIN_WIDTH,
  parameter int unsigned VL_MARGIN_WIDTH = VGA_VL_MARGIN_WIDTH,
  parameter int unsigned VR_MARGIN_WIDTH = VGA_VR_MARGIN_WIDTH
);

  logic                       Load_config;
  logic [HL_MARGIN_WIDTH-1:0] H_left_margin;
  logic [HR_MARGIN_WIDTH-1:0] H_right_margin;
  logic [VL_MARGIN_WIDTH-1:0] V_left_margin;
  logic [VR_MARGIN_WIDTH-1:0] V_right_margin;
  logic [REZ_MAX_WIDTH-1:0]   H_count_max;
  logic [REZ_MAX_WIDTH-1:0]   V_count_max;
  logic [PULSE_WIDTH-1:0]     H_sync_pulse;
  logic [PULSE_WIDTH-1:0]     V_sync_pulse;

  logic                       H_sync;
  logic                       V_sync;
  logic                       Active;
  logic [REZ_MAX_WIDTH-1:0]   Pixel_x;
  logic [REZ_MAX_WIDTH-1:0]   Pixel_y;
  logic                       Frame_start;
  logic                       Config_err;

  modport master (
    output Load_config, H_left_margin, H_right_margin, V_left_margin, V_right_margin,
           H_count_max, V_count_max, H_sync_pulse, V_sync_pulse,
    input  H_sync, V_sync, Active, Pixel_x, Pixel_y, Frame_start, Config_err
  );

  modport slave (
    input  Load_config, H_left_margin, H_right_margin, V_left_margin, V_right_margin,
           H_count_max, V_count_max, H_sync_pulse, V_sync_pulse,
    output H_sync, V_sync, Active, Pixel_x, Pixel_y, Frame_start, Config_err
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping counter plus SYNC/BACK/ACTIVE/FRONT decode and
// the offset of the count from the first active position.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned CNT_W   = VGA_REZ_MAX_WIDTH,
  parameter int unsigned SYNC_W  = VGA_PULSE_WIDTH,
  parameter int unsigned LEFT_W  = VGA_HL_MARGIN_WIDTH,
  parameter int unsigned RIGHT_W = VGA_HR_MARGIN_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               advance,
  input  logic [CNT_W-1:0]   count_max,
  input  logic [SYNC_W-1:0]  sync_len,
  input  logic [LEFT_W-1:0]  left_margin,
  input  logic [RIGHT_W-1:0] right_margin,
  output logic [CNT_W-1:0]   cnt,
  output logic               at_max,
  output region_e            region,
  output logic [CNT_W-1:0]   pos
);

  // One extra bit so sync+left and the region bounds never wrap.
  localparam int unsigned EW = CNT_W + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [EW-1:0]    cnt_x, sync_x, act_start_x, act_end_x;

  assign at_max = (cnt_q == count_max);
  assign cnt    = cnt_q;

  always_comb begin
    // NOTE: default first so every path assigns cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (advance) begin
      cnt_d = at_max ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking for all flop updates so every register samples pre-edge values.
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_x       = EW'(cnt_q);
  assign sync_x      = EW'(sync_len);
  assign act_start_x = sync_x + EW'(left_margin);
  assign act_end_x   = EW'(count_max) - EW'(right_margin);

  // Zero-length BACK/FRONT fall out naturally: their compare windows are empty.
  always_comb begin
    region = FRONT;
    if (cnt_x < sync_x) begin
      region = SYNC;
    end else if (cnt_x < act_start_x) begin
      region = BACK;
    end else if (cnt_x <= act_end_x) begin
      region = ACTIVE;
    end
  end

  assign pos = CNT_W'(cnt_x - act_start_x);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator with shadowed, frame-boundary-applied configuration.
// Define VGA_SYNC_ACTIVE_LOW_EN for active-low H_sync/V_sync.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned REZ_MAX_WIDTH      = VGA_REZ_MAX_WIDTH,
  parameter int unsigned PULSE_WIDTH        = VGA_PULSE_WIDTH,
  parameter int unsigned HL_MARGIN_WIDTH    = VGA_HL_MARGIN_WIDTH,
  parameter int unsigned HR_MARGIN_WIDTH    = VGA_HR_MARGIN_WIDTH,
  parameter int unsigned VL_MARGIN_WIDTH    = VGA_VL_MARGIN_WIDTH,
  parameter int unsigned VR_MARGIN_WIDTH    = VGA_VR_MARGIN_WIDTH,
  parameter int unsigned RST_H_COUNT_MAX    = DEF_H_COUNT_MAX,
  parameter int unsigned RST_H_SYNC_PULSE   = DEF_H_SYNC_PULSE,
  parameter int unsigned RST_H_LEFT_MARGIN  = DEF_H_LEFT_MARGIN,
  parameter int unsigned RST_H_RIGHT_MARGIN = DEF_H_RIGHT_MARGIN,
  parameter int unsigned RST_V_COUNT_MAX    = DEF_V_COUNT_MAX,
  parameter int unsigned RST_V_SYNC_PULSE   = DEF_V_SYNC_PULSE,
  parameter int unsigned RST_V_LEFT_MARGIN  = DEF_V_LEFT_MARGIN,
  parameter int unsigned RST_V_RIGHT_MARGIN = DEF_V_RIGHT_MARGIN
) (
  input  logic             Clk,
  input  logic             Rst,
  vga_timing_gen_if.slave  bus
);

  localparam int unsigned EW = REZ_MAX_WIDTH + 1;

`ifdef VGA_SYNC_ACTIVE_LOW_EN
  localparam logic SYNC_ON = 1'b0;
`else
  localparam logic SYNC_ON = 1'b1;
`endif

  typedef struct packed {
    logic [REZ_MAX_WIDTH-1:0]   h_max;
    logic [PULSE_WIDTH-1:0]     h_sync;
    logic [HL_MARGIN_WIDTH-1:0] h_left;
    logic [HR_MARGIN_WIDTH-1:0] h_right;
    logic [REZ_MAX_WIDTH-1:0]   v_max;
    logic [PULSE_WIDTH-1:0]     v_sync;
    logic [VL_MARGIN_WIDTH-1:0] v_left;
    logic [VR_MARGIN_WIDTH-1:0] v_right;
  } cfg_t;

  localparam cfg_t RST_CFG = '{
    h_max:   REZ_MAX_WIDTH'(RST_H_COUNT_MAX),
    h_sync:  PULSE_WIDTH'(RST_H_SYNC_PULSE),
    h_left:  HL_MARGIN_WIDTH'(RST_H_LEFT_MARGIN),
    h_right: HR_MARGIN_WIDTH'(RST_H_RIGHT_MARGIN),
    v_max:   REZ_MAX_WIDTH'(RST_V_COUNT_MAX),
    v_sync:  PULSE_WIDTH'(RST_V_SYNC_PULSE),
    v_left:  VL_MARGIN_WIDTH'(RST_V_LEFT_MARGIN),
    v_right: VR_MARGIN_WIDTH'(RST_V_RIGHT_MARGIN)
  };

  function automatic logic axis_fits(input logic [EW-1:0] max_x, input logic [EW-1:0] sync_x,
                                     input logic [EW-1:0] left_x, input logic [EW-1:0] right_x);
    return (sync_x != '0) && ((sync_x + left_x + right_x) <= max_x);
  endfunction

  cfg_t    cfg_in, applied_q, applied_d, pending_q, pending_d;
  logic    pending_vld_q, pending_vld_d;
  logic    cfg_ok, boundary;

  logic [REZ_MAX_WIDTH-1:0] h_cnt, v_cnt, h_pos, v_pos;
  logic                     h_at_max, v_at_max;
  region_e                  h_region, v_region;

  logic                     h_sync_q, h_sync_d, v_sync_q, v_sync_d;
  logic                     active_q, active_d;
  logic [REZ_MAX_WIDTH-1:0] pixel_x_q, pixel_x_d, pixel_y_q, pixel_y_d;
  logic                     frame_start_q, frame_start_d;
  logic                     config_err_q, config_err_d;

  assign cfg_in = '{
    h_max:   bus.H_count_max,
    h_sync:  bus.H_sync_pulse,
    h_left:  bus.H_left_margin,
    h_right: bus.H_right_margin,
    v_max:   bus.V_count_max,
    v_sync:  bus.V_sync_pulse,
    v_left:  bus.V_left_margin,
    v_right: bus.V_right_margin
  };

  assign cfg_ok = axis_fits(EW'(cfg_in.h_max), EW'(cfg_in.h_sync), EW'(cfg_in.h_left), EW'(cfg_in.h_right))
               && axis_fits(EW'(cfg_in.v_max), EW'(cfg_in.v_sync), EW'(cfg_in.v_left), EW'(cfg_in.v_right));

  assign boundary = h_at_max && v_at_max;

  // A valid strobe on the boundary cycle lands in pending_d and is applied at once.
  always_comb begin
    pending_d     = pending_q;
    pending_vld_d = pending_vld_q;
    applied_d     = applied_q;
    if (bus.Load_config && cfg_ok) begin
      pending_d     = cfg_in;
      pending_vld_d = 1'b1;
    end
    if (boundary && pending_vld_d) begin
      applied_d     = pending_d;
      pending_vld_d = 1'b0;
    end
  end

  vga_axis_counter #(
    .CNT_W(REZ_MAX_WIDTH), .SYNC_W(PULSE_WIDTH),
    .LEFT_W(HL_MARGIN_WIDTH), .RIGHT_W(HR_MARGIN_WIDTH)
  ) u_h_axis (
    .clk(Clk), .rst(Rst), .advance(1'b1),
    .count_max(applied_q.h_max), .sync_len(applied_q.h_sync),
    .left_margin(applied_q.h_left), .right_margin(applied_q.h_right),
    .cnt(h_cnt), .at_max(h_at_max), .region(h_region), .pos(h_pos)
  );

  vga_axis_counter #(
    .CNT_W(REZ_MAX_WIDTH), .SYNC_W(PULSE_WIDTH),
    .LEFT_W(VL_MARGIN_WIDTH), .RIGHT_W(VR_MARGIN_WIDTH)
  ) u_v_axis (
    .clk(Clk), .rst(Rst), .advance(h_at_max),
    .count_max(applied_q.v_max), .sync_len(applied_q.v_sync),
    .left_margin(applied_q.v_left), .right_margin(applied_q.v_right),
    .cnt(v_cnt), .at_max(v_at_max), .region(v_region), .pos(v_pos)
  );

  always_comb begin
    h_sync_d      = (h_region == SYNC) ? SYNC_ON : ~SYNC_ON;
    v_sync_d      = (v_region == SYNC) ? SYNC_ON : ~SYNC_ON;
    active_d      = (h_region == ACTIVE) && (v_region == ACTIVE);
    pixel_x_d     = active_d ? h_pos : '0;
    pixel_y_d     = active_d ? v_pos : '0;
    frame_start_d = (h_cnt == '0) && (v_cnt == '0);
    config_err_d  = bus.Load_config && !cfg_ok;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      applied_q     <= RST_CFG;
      pending_q     <= RST_CFG;
      pending_vld_q <= 1'b0;
      h_sync_q      <= ~SYNC_ON;
      v_sync_q      <= ~SYNC_ON;
      active_q      <= 1'b0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      frame_start_q <= 1'b0;
      config_err_q  <= 1'b0;
    end else begin
      applied_q     <= applied_d;
      pending_q     <= pending_d;
      pending_vld_q <= pending_vld_d;
      h_sync_q      <= h_sync_d;
      v_sync_q      <= v_sync_d;
      active_q      <= active_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      frame_start_q <= frame_start_d;
      config_err_q  <= config_err_d;
    end
  end

  assign bus.H_sync      = h_sync_q;
  assign bus.V_sync      = v_sync_q;
  assign bus.Active      = active_q;
  assign bus.Pixel_x     = pixel_x_q;
  assign bus.Pixel_y     = pixel_y_q;
  assign bus.Frame_start = frame_start_q;
  assign bus.Config_err  = config_err_q;

endmodule
